frame_scan_out: RTL and testbench
=================================

Name: frame_scan_out

Overview:
- Downstream consumer of the 24-bit RGB frame buffer, on the buffer's read-clock side.
- Generates raster timing: horizontal/vertical counters, hsync, vsync and data-enable.
- Issues one read request per active pixel to the frame buffer and aligns the returned 24-bit pixels with the delayed timing signals.
- Output drives the display transmitter pixel bus directly.
- Flags read underflow when the buffer is empty during the active region.

Parameters:
- H_ACTIVE, 8, active pixels per line
- H_FP, 2, horizontal front porch, in clocks
- H_SYNC, 2, hsync width, in clocks
- H_BP, 2, horizontal back porch, in clocks
- V_ACTIVE, 4, active lines per frame
- V_FP, 1, vertical front porch, in lines
- V_SYNC, 1, vsync width, in lines
- V_BP, 1, vertical back porch, in lines
- SYNC_POL, 0, asserted level of hsync_out/vsync_out (0 = active-low)
- RD_LAT, 1, frame buffer read latency in clocks (rd_en to data valid), range 1..4
- UNDERFLOW_COLOR, 24'hFF00FF, pixel substituted on underflow

Ports:
- rd_clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  1 = scan; 0 = counters held at origin
- data_in  in  24  pixel from the frame buffer read port
- buf_empty  in  1  frame buffer has no readable data
- rd_en_out  out  1  read request to the frame buffer, active-high
- pixel_out  out  24  RGB pixel, valid when de_out=1, else 0
- de_out  out  1  data enable
- hsync_out  out  1  horizontal sync, level per SYNC_POL
- vsync_out  out  1  vertical sync, level per SYNC_POL
- frame_start  out  1  one-clock pulse aligned with the first active pixel of a frame
- underflow  out  1  sticky underflow flag

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counter widths are clog2 of the totals.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h_cnt wrap and wraps 0 after V_TOTAL-1.
- Region order: active, front porch, sync, back porch.
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
- rd_en_out = run && active && !buf_empty. This is a combinational decode of registered counters and buf_empty only.
- A slot is "starved" when active && buf_empty.
- Pipeline: active, hs, vs, starved and first-pixel (h=0,v=0) pass through an (RD_LAT+1)-stage register delay.
- data_in is registered once at stage RD_LAT, so pixel_out is a register.
- Latency: rd_en_out high in cycle t gives de_out=1 and pixel_out = the data returned for that read in cycle t+RD_LAT+1. hsync_out, vsync_out and frame_start use the same delay.
- pixel_out = 0 when de_out=0. pixel_out = UNDERFLOW_COLOR when the delayed starved bit is set.
- Sync outputs: asserted level = SYNC_POL, deasserted = ~SYNC_POL.
- underflow sets on any starved slot, as seen at the output stage. It clears only on reset.
- run=0: counters forced to 0,0 and rd_en_out=0. The pipeline keeps shifting with timing bits forced inactive, so outputs go idle after RD_LAT+1 clocks.
- run rising: the scan starts at h=0,v=0 on that cycle.
- Reset values, applied for one or more cycles and also mid-frame:
  - h_cnt=v_cnt=0, all pipe stages 0, rd_en_out=0, pixel_out=0, de_out=0, frame_start=0, underflow=0.
  - hsync_out=vsync_out=~SYNC_POL.
  - On the first cycle after reset release with run=1, the state is h=0,v=0 and rd_en_out=1 (unless buf_empty).
- buf_empty toggling mid-line affects only the slots where it is high. There is no retry and no skew: the raster never stalls.

Test Plan:
- Defaults, run=1, buf_empty=0, data_in = incrementing counter advanced on rd_en_out:
  - rd_en_out high for 8 clocks per line over 4 lines, then low for 3 lines.
  - de_out is the same pattern delayed 2 clocks; pixel_out reproduces the sequence 1..32 in order.
- Sync timing: hsync_out low for exactly clocks 10-11 of each 14-clock line (delayed 2). vsync_out low for the whole of line 5 of the 7-line frame. Frame period = 98 clocks; frame_start pulses every 98 clocks, coincident with the first de_out.
- Underflow: buf_empty=1 for active pixel 3 of line 0:
  - rd_en_out is low in that slot.
  - pixel_out=FF00FF with de_out=1 two clocks later.
  - underflow goes 1 and stays 1 through later clean frames.
- Reset mid-line (h=5,v=2) for one clock:
  - Next cycle all outputs at reset values, syncs=1.
  - Following cycle rd_en_out=1 at h=0,v=0; underflow=0.
- run drop mid-frame: rd_en_out=0 on the same cycle; de_out=0 within 2 clocks. On run re-assertion, frame_start appears 2 clocks later.
- RD_LAT=3, SYNC_POL=1: de_out lags rd_en_out by 4 clocks. Syncs idle low and pulse high. Pixel ordering is preserved.

Source files
------------

// File: rtl/frame_scan_out.sv
// Raster scan-out for the RGB frame buffer read side: generates display timing,
// issues one read per active pixel and re-aligns returned pixels with delayed timing.
module frame_scan_out #(
    parameter int unsigned H_ACTIVE        = 8,
    parameter int unsigned H_FP            = 2,
    parameter int unsigned H_SYNC          = 2,
    parameter int unsigned H_BP            = 2,
    parameter int unsigned V_ACTIVE        = 4,
    parameter int unsigned V_FP            = 1,
    parameter int unsigned V_SYNC          = 1,
    parameter int unsigned V_BP            = 1,
    parameter bit          SYNC_POL        = 1'b0,
    parameter int unsigned RD_LAT          = 1,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic        rd_clk,
    input  logic        reset,
    input  logic        run,
    input  logic [23:0] data_in,
    input  logic        buf_empty,
    output logic        rd_en_out,
    output logic [23:0] pixel_out,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
    localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
    localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic starved;
        logic first;
    } tbits_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    logic active;
    logic hs;
    logic vs;

    tbits_t              cur;
    tbits_t              last;
    tbits_t [RD_LAT-1:0] pipe;
    tbits_t [RD_LAT:0]   pipe_next;

    // Counters sit at the origin while idle, so a run rising edge scans h=0,v=0 at once.
    always_ff @(posedge rd_clk) begin
        if (reset || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        active = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
        hs     = (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END);
        vs     = (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END);
    end

    always_comb begin
        cur = '0;
        if (run) begin
            cur.act     = active;
            cur.hs      = hs;
            cur.vs      = vs;
            cur.starved = active && buf_empty;
            cur.first   = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign rd_en_out = run && !reset && active && !buf_empty;

    always_comb begin
        pipe_next = {pipe, cur};
        last      = pipe[RD_LAT-1];
    end

    // Output stage is pipeline stage RD_LAT; data_in is valid there for the read issued RD_LAT clocks earlier.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            pipe        <= '0;
            pixel_out   <= '0;
            de_out      <= 1'b0;
            hsync_out   <= ~SYNC_POL;
            vsync_out   <= ~SYNC_POL;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            pipe        <= pipe_next[RD_LAT-1:0];
            de_out      <= last.act;
            hsync_out   <= last.hs ? SYNC_POL : ~SYNC_POL;
            vsync_out   <= last.vs ? SYNC_POL : ~SYNC_POL;
            frame_start <= last.first;
            underflow   <= underflow | last.starved;
            if (!last.act) begin
                pixel_out <= '0;
            end else if (last.starved) begin
                pixel_out <= UNDERFLOW_COLOR;
            end else begin
                pixel_out <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_frame_scan_out.sv
// Scoreboard bench for frame_scan_out: default instance (RD_LAT=1, active-low syncs)
// and a RD_LAT=3 / active-high-sync instance, both fed by a frame buffer model.
module tb_frame_scan_out;

    localparam logic [23:0] UF_COLOR = 24'hFF00FF;
    localparam logic [23:0] NO_DATA  = 24'hDEAD00;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic first;
        logic starved;
    } tb_bits_t;

    typedef struct {
        logic [23:0] px;
        int          stamp;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [23:0] din      [2];
    logic        empty    [2];
    logic        rd_o     [2];
    logic [23:0] px_o     [2];
    logic        de_o     [2];
    logic        hs_o     [2];
    logic        vs_o     [2];
    logic        fs_o     [2];
    logic        uf_o     [2];

    always #5 clk = ~clk;

    frame_scan_out u0 (
        .rd_clk(clk), .reset(reset), .run(run), .data_in(din[0]), .buf_empty(empty[0]),
        .rd_en_out(rd_o[0]), .pixel_out(px_o[0]), .de_out(de_o[0]), .hsync_out(hs_o[0]),
        .vsync_out(vs_o[0]), .frame_start(fs_o[0]), .underflow(uf_o[0])
    );

    frame_scan_out #(.RD_LAT(3), .SYNC_POL(1'b1)) u1 (
        .rd_clk(clk), .reset(reset), .run(run), .data_in(din[1]), .buf_empty(empty[1]),
        .rd_en_out(rd_o[1]), .pixel_out(px_o[1]), .de_out(de_o[1]), .hsync_out(hs_o[1]),
        .vsync_out(vs_o[1]), .frame_start(fs_o[1]), .underflow(uf_o[1])
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          sp = 0;
    bit          chk_en = 1'b0;
    bit          reset_s, run_s, empty_s;
    tb_bits_t    hist   [2][8];
    bit          uf_exp [2];
    logic [23:0] fbq    [2][8];
    int          fb_cnt [2];
    int          exp_cnt[2];
    sb_t         q0[$];
    sb_t         q1[$];
    sb_t         mon_e;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    // Hand-derived raster: 14-clock lines (8 active, sync at 10-11), 7-line frames (sync line 5).
    function automatic tb_bits_t raster(input int p);
        tb_bits_t r;
        int h, v;
        h = p % 14;
        v = p / 14;
        r = '0;
        r.act   = (h < 8) && (v < 4);
        r.hs    = (h == 10) || (h == 11);
        r.vs    = (v == 5);
        r.first = (p == 0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input sb_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drop_in_flight(input int i, input int limit);
        if (i == 0) begin
            while (q0.size() > 0 && q0[q0.size()-1].stamp > limit) void'(q0.pop_back());
        end else begin
            while (q1.size() > 0 && q1[q1.size()-1].stamp > limit) void'(q1.pop_back());
        end
    endtask

    task automatic step();
        tb_bits_t cur, e;
        logic     pol;
        sb_t      ent;
        @(negedge clk);
        reset    = reset_s;
        run      = run_s;
        empty[0] = empty_s;
        empty[1] = 1'b0;
        for (int i = 0; i < 2; i++) din[i] = fbq[i][(cyc + 1 - (lat_of(i) - 1)) & 7];
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            pol = (i == 1);
            cur = (run_s && !reset_s) ? raster(sp) : '0;
            if (i == 0) cur.starved = cur.act && empty_s;
            e = hist[i][(cyc - lat_of(i)) & 7];
            uf_exp[i] = uf_exp[i] | e.starved;
            if (chk_en) begin
                check($sformatf("u%0d.rd_en", i), 32'(rd_o[i]), 32'(cur.act && !cur.starved));
                check($sformatf("u%0d.de", i), 32'(de_o[i]), 32'(e.act));
                check($sformatf("u%0d.hsync", i), 32'(hs_o[i]), 32'(e.hs ? pol : !pol));
                check($sformatf("u%0d.vsync", i), 32'(vs_o[i]), 32'(e.vs ? pol : !pol));
                check($sformatf("u%0d.frame_start", i), 32'(fs_o[i]), 32'(e.first));
                check($sformatf("u%0d.underflow", i), 32'(uf_o[i]), 32'(uf_exp[i]));
                if (!e.act) check($sformatf("u%0d.pixel_idle", i), 32'(px_o[i]), 32'(0));
            end
            if (rd_o[i] === 1'b1) begin
                fb_cnt[i]++;
                fbq[i][cyc & 7] = 24'(fb_cnt[i]);
            end else begin
                fbq[i][cyc & 7] = NO_DATA;
            end
            if (cur.starved) begin
                ent.px = UF_COLOR;
                ent.stamp = cyc;
                push(i, ent);
            end else if (cur.act) begin
                exp_cnt[i]++;
                ent.px = 24'(exp_cnt[i]);
                ent.stamp = cyc;
                push(i, ent);
            end
            hist[i][cyc & 7] = cur;
            // Synchronous reset wipes everything still in flight inside the DUT.
            if (reset_s) begin
                for (int k = 0; k < 8; k++) hist[i][k] = '0;
                uf_exp[i] = 1'b0;
                drop_in_flight(i, cyc - lat_of(i));
            end
        end
        sp = (reset_s || !run_s) ? 0 : (sp + 1) % 98;
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            if (de_o[0] === 1'b1) begin
                check("u0.sb_avail", 32'(q0.size() > 0), 32'(1));
                if (q0.size() > 0) begin
                    mon_e = q0.pop_front();
                    check("u0.pixel", 32'(px_o[0]), 32'(mon_e.px));
                    check("u0.latency", 32'(cyc), 32'(mon_e.stamp + 2));
                end
            end
            if (de_o[1] === 1'b1) begin
                check("u1.sb_avail", 32'(q1.size() > 0), 32'(1));
                if (q1.size() > 0) begin
                    mon_e = q1.pop_front();
                    check("u1.pixel", 32'(px_o[1]), 32'(mon_e.px));
                    check("u1.latency", 32'(cyc), 32'(mon_e.stamp + 4));
                end
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) begin
                hist[i][k] = '0;
                fbq[i][k]  = NO_DATA;
            end
            uf_exp[i]  = 1'b0;
            fb_cnt[i]  = 0;
            exp_cnt[i] = 0;
            din[i]     = NO_DATA;
            empty[i]   = 1'b0;
        end
        reset = 1'b1;
        run   = 1'b1;
        reset_s = 1'b1;
        run_s   = 1'b1;
        empty_s = 1'b0;

        step();
        chk_en = 1'b1;
        step();
        reset_s = 1'b0;

        // Two clean frames: pixels 1..64 in order, syncs and frame_start every 98 clocks.
        repeat (196) step();

        // Starve active pixel 3 of line 0.
        repeat (3) step();
        empty_s = 1'b1;
        step();
        empty_s = 1'b0;
        repeat (94) step();

        // Clean frame: underflow must stay set.
        repeat (98) step();

        // One-clock reset at h=5, v=2.
        repeat (33) step();
        reset_s = 1'b1;
        step();
        reset_s = 1'b0;

        // Drop run mid-line, then restart from the origin.
        repeat (20) step();
        run_s = 1'b0;
        repeat (5) step();
        run_s = 1'b1;
        repeat (110) step();

        run_s = 1'b0;
        repeat (6) step();

        check("u0.sb_drained", 32'(q0.size()), 32'(0));
        check("u1.sb_drained", 32'(q1.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
